// File: rtl/gray_code_counter.sv
// Up/down binary counter presenting its count as registered reflected Gray code
// over a valid/ready handshake; load clamps to MAX_COUNT.
module gray_code_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = (2**WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] g,
   output logic             g_valid,
   input  logic             g_ready,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [WIDTH-1:0] bin_r;
   logic [WIDTH-1:0] g_r;
   logic             g_valid_r;
   logic             wrap_r;

   logic [WIDTH-1:0] step_bin_s;
   logic             step_wrap_s;
   logic [WIDTH-1:0] bin_nxt_s;
   logic             g_valid_nxt_s;
   logic             wrap_nxt_s;

   // Candidate next count for one step in the sampled direction.
   always_comb begin
      step_bin_s  = bin_r;
      step_wrap_s = 1'b0;
      if (up_dn) begin
         if (bin_r == MAX_VAL) begin
            step_bin_s  = ZERO;
            step_wrap_s = 1'b1;
         end else begin
            step_bin_s  = bin_r + ONE;
         end
      end else begin
         if (bin_r == ZERO) begin
            step_bin_s  = MAX_VAL;
            step_wrap_s = 1'b1;
         end else begin
            step_bin_s  = bin_r - ONE;
         end
      end
   end

   // Handshake priority: load, then transfer, then refill of an empty slot.
   always_comb begin
      bin_nxt_s     = bin_r;
      g_valid_nxt_s = g_valid_r;
      wrap_nxt_s    = 1'b0;
      if (load) begin
         bin_nxt_s     = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         g_valid_nxt_s = 1'b1;
      end else if (g_valid_r && g_ready) begin
         if (en) begin
            bin_nxt_s     = step_bin_s;
            wrap_nxt_s    = step_wrap_s;
            g_valid_nxt_s = 1'b1;
         end else begin
            g_valid_nxt_s = 1'b0;
         end
      end else if (!g_valid_r && en) begin
         bin_nxt_s     = step_bin_s;
         wrap_nxt_s    = step_wrap_s;
         g_valid_nxt_s = 1'b1;
      end else begin
         bin_nxt_s     = bin_r;
         g_valid_nxt_s = g_valid_r;
      end
   end

   // State and registered Gray output; g is re-encoded from the next count so it never lags bin.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_r     <= ZERO;
         g_r       <= ZERO;
         g_valid_r <= 1'b1;
         wrap_r    <= 1'b0;
      end else begin
         bin_r     <= bin_nxt_s;
         g_r       <= bin2gray(bin_nxt_s);
         g_valid_r <= g_valid_nxt_s;
         wrap_r    <= wrap_nxt_s;
      end
   end

   assign g       = g_r;
   assign g_valid = g_valid_r;
   assign wrap    = wrap_r;
   assign tc      = up_dn ? (bin_r == MAX_VAL) : (bin_r == ZERO);

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: full-range (MAX_COUNT=15) and clamped
// (MAX_COUNT=9) instances driven with shared stimulus.
module tb_gray_code_counter;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, load, g_ready;
   logic [3:0] load_val;
   logic [3:0] g, g9;
   logic       g_valid, g_valid9, tc, tc9, wrap, wrap9;

   int n_vec = 0;
   int n_mis = 0;

   int   m_bin [2];
   logic m_v   [2];
   logic m_w   [2];
   int   m_max [2] = '{15, 9};
   logic [5:0] q0 [$];
   logic [5:0] q1 [$];

   logic [3:0] up_tab [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
   logic [3:0] dn_tab [3]  = '{4'b1000, 4'b1001, 4'b1011};

   always #5 clk = ~clk;

   gray_code_counter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .g(g), .g_valid(g_valid), .g_ready(g_ready), .tc(tc), .wrap(wrap));

   gray_code_counter #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .g(g9), .g_valid(g_valid9), .g_ready(g_ready), .tc(tc9), .wrap(wrap9));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] gray4(input int b);
      logic [3:0] x;
      x = b[3:0];
      return x ^ (x >> 1);
   endfunction

   function automatic int g2b(input logic [3:0] gc);
      logic [3:0] b;
      b[3] = gc[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ gc[i];
      return int'(b);
   endfunction

   // Behavioural model of one counter for the inputs currently applied.
   task automatic model_update(input int k);
      int mx;
      mx = m_max[k];
      if (rst) begin
         m_bin[k] = 0; m_v[k] = 1'b1; m_w[k] = 1'b0;
      end else if (load) begin
         m_bin[k] = (int'(load_val) > mx) ? mx : int'(load_val);
         m_v[k] = 1'b1; m_w[k] = 1'b0;
      end else begin
         m_w[k] = 1'b0;
         if ((m_v[k] && g_ready && en) || (!m_v[k] && en)) begin
            if (up_dn) begin
               if (m_bin[k] == mx) begin m_bin[k] = 0; m_w[k] = 1'b1; end
               else m_bin[k] = m_bin[k] + 1;
            end else begin
               if (m_bin[k] == 0) begin m_bin[k] = mx; m_w[k] = 1'b1; end
               else m_bin[k] = m_bin[k] - 1;
            end
            m_v[k] = 1'b1;
         end else if (m_v[k] && g_ready) begin
            m_v[k] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic [5:0] e;
      logic       etc;
      for (int k = 0; k < 2; k++) model_update(k);
      q0.push_back({gray4(m_bin[0]), m_v[0], m_w[0]});
      q1.push_back({gray4(m_bin[1]), m_v[1], m_w[1]});
      @(posedge clk);
      #1;
      e = q0.pop_front();
      check_eq("g", g, e[5:2]);
      check_eq("g_valid", g_valid, e[1]);
      check_eq("wrap", wrap, e[0]);
      etc = up_dn ? (m_bin[0] == 15) : (m_bin[0] == 0);
      check_eq("tc", tc, etc);
      e = q1.pop_front();
      check_eq("g9", g9, e[5:2]);
      check_eq("g_valid9", g_valid9, e[1]);
      check_eq("wrap9", wrap9, e[0]);
      etc = up_dn ? (m_bin[1] == 9) : (m_bin[1] == 0);
      check_eq("tc9", tc9, etc);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; g_ready = 1'b0; load_val = 4'd0;
      m_bin = '{0, 0}; m_v = '{1'b1, 1'b1}; m_w = '{1'b0, 1'b0};
      #2;
      tick();
      check_eq("rst_g", g, 4'b0000);
      check_eq("rst_valid", g_valid, 1'b1);
      check_eq("rst_wrap", wrap, 1'b0);

      // full up-count cycle through wrap
      rst = 1'b0; en = 1'b1; g_ready = 1'b1; up_dn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check_eq("up_seq", g, up_tab[i]);
         check_eq("up_wrap", wrap, (i == 16) ? 1'b1 : 1'b0);
         check_eq("up_conv", g2b(g), i % 16);
         if (i == 15) check_eq("up_tc", tc, 1'b1);
      end

      // down count from reset
      rst = 1'b1; tick(); rst = 1'b0; up_dn = 1'b0;
      #1;
      check_eq("dn_tc0", tc, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("dn_seq", g, dn_tab[i]);
         check_eq("dn_wrap", wrap, (i == 0) ? 1'b1 : 1'b0);
      end

      // backpressure with up_dn toggling while stalled
      rst = 1'b1; tick(); rst = 1'b0; up_dn = 1'b1;
      tick(); tick();
      check_eq("bp_start", g, 4'b0011);
      g_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         up_dn = i[0];
         tick();
         check_eq("bp_hold_g", g, 4'b0011);
         check_eq("bp_hold_v", g_valid, 1'b1);
      end
      up_dn = 1'b1; g_ready = 1'b1;
      tick();
      check_eq("bp_release", g, 4'b0010);

      // en=0 after transfer drains the slot, en=1 refills it
      en = 1'b0;
      tick();
      check_eq("drain_v", g_valid, 1'b0);
      check_eq("drain_g", g, 4'b0010);
      tick();
      en = 1'b1;
      tick();
      check_eq("refill_v", g_valid, 1'b1);
      check_eq("refill_g", g, 4'b0110);

      // load over an unaccepted code, with clamping on the MAX_COUNT=9 instance
      g_ready = 1'b0; load = 1'b1; load_val = 4'b1010;
      tick();
      check_eq("ld_g", g, 4'b1111);
      check_eq("ld_g9", g9, 4'b1101);
      check_eq("ld_wrap", wrap, 1'b0);
      load_val = 4'b1100;
      tick();
      check_eq("ld_clamp9", g9, 4'b1101);
      check_eq("ld_g12", g, 4'b1010);
      load_val = 4'b0011;
      tick();
      check_eq("ld_small9", g9, 4'b0010);
      load = 1'b0;

      // reset beats a same-cycle load mid-sequence
      rst = 1'b1; tick(); rst = 1'b0; en = 1'b1; g_ready = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check_eq("mid_g", g, 4'b0110);
      g_ready = 1'b0; load = 1'b1; load_val = 4'd5; rst = 1'b1;
      tick();
      check_eq("mid_rst_g", g, 4'b0000);
      check_eq("mid_rst_v", g_valid, 1'b1);
      check_eq("mid_rst_wrap", wrap, 1'b0);
      rst = 1'b0; load = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
